// File: rtl/pe_processing_element.sv
// Signed fixed-point multiply-accumulate processing element.
//
// Accumulates PERIOD products of weight * inmap (Q4.3 x Q4.3 -> Q8.6), adds the
// bias aligned to Q.6 on the final beat of the window, and registers both a
// saturated 16-bit Q9.6 result and a saturated 8-bit Q4.3 feature-map value.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   weight     - signed Q4.3 kernel weight
//   inmap      - signed Q4.3 input feature-map sample
//   inmap_vld  - inmap valid this cycle
//   weight_vld - weight valid this cycle
//   bias       - signed Q4.3 bias, used only on the final beat
//   outmap     - signed Q4.3 saturated result
//   outmap_vld - one-cycle pulse marking new outmap / vldbiased
//   vldbiased  - signed Q9.6 saturated full-precision result

module pe_processing_element #(
  parameter int unsigned PERIOD = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  weight,
  input  logic [7:0]  inmap,
  input  logic        inmap_vld,
  input  logic        weight_vld,
  input  logic [7:0]  bias,
  output logic [7:0]  outmap,
  output logic        outmap_vld,
  output logic [15:0] vldbiased
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned AccW = 17 + $clog2(PERIOD);
  // One spare bit so the final-beat sum (acc + p + bias) can never wrap.
  localparam int unsigned SumW = AccW + 1;

  localparam logic signed [SumW-1:0] Max16 = SumW'(32767);
  localparam logic signed [SumW-1:0] Min16 = SumW'(-32768);
  localparam logic signed [SumW-1:0] Max8  = SumW'(127);
  localparam logic signed [SumW-1:0] Min8  = SumW'(-128);

  logic signed [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [7:0]             outmap_q, outmap_d;
  logic [15:0]            vb_q, vb_d;
  logic                   vld_q, vld_d;

  logic                   beat;
  logic                   last;
  logic signed [15:0]     w_ext;
  logic signed [15:0]     x_ext;
  logic signed [15:0]     prod;
  logic signed [AccW-1:0] prod_acc;
  logic signed [SumW-1:0] acc_ext;
  logic signed [SumW-1:0] prod_ext;
  logic signed [SumW-1:0] bias_ext;
  logic signed [SumW-1:0] sum;
  logic signed [SumW-1:0] sum_shr;
  logic [15:0]            sat16;
  logic [7:0]             sat8;

  always_comb begin
    beat = inmap_vld & weight_vld;
    last = (cnt_q == CntW'(PERIOD - 1));

    // Q4.3 * Q4.3 fits exactly in 16 bits, so the low half of the
    // sign-extended product is the full result.
    w_ext    = {{8{weight[7]}}, weight};
    x_ext    = {{8{inmap[7]}}, inmap};
    prod     = w_ext * x_ext;
    prod_acc = {{(AccW - 16){prod[15]}}, prod};

    acc_ext  = {acc_q[AccW-1], acc_q};
    prod_ext = {{(SumW - 16){prod[15]}}, prod};
    // Bias moves from Q.3 to Q.6.
    bias_ext = {{(SumW - 11){bias[7]}}, bias, 3'b000};
    sum      = acc_ext + prod_ext + bias_ext;
    // Arithmetic shift gives floor rounding back to Q.3.
    sum_shr  = sum >>> 3;

    if (sum > Max16) begin
      sat16 = 16'h7fff;
    end else if (sum < Min16) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = sum[15:0];
    end

    if (sum_shr > Max8) begin
      sat8 = 8'h7f;
    end else if (sum_shr < Min8) begin
      sat8 = 8'h80;
    end else begin
      sat8 = sum_shr[7:0];
    end
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    outmap_d = outmap_q;
    vb_d     = vb_q;
    vld_d    = 1'b0;
    if (beat) begin
      if (last) begin
        acc_d    = '0;
        cnt_d    = '0;
        outmap_d = sat8;
        vb_d     = sat16;
        vld_d    = 1'b1;
      end else begin
        acc_d = acc_q + prod_acc;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      outmap_q <= '0;
      vb_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      outmap_q <= outmap_d;
      vb_q     <= vb_d;
      vld_q    <= vld_d;
    end
  end

  assign outmap     = outmap_q;
  assign vldbiased  = vb_q;
  assign outmap_vld = vld_q;

endmodule

// File: tb/tb_pe_processing_element.sv
// Self-checking bench for pe_processing_element: a PERIOD=25 instance driven
// from a vector table plus control-corner sequences, and a PERIOD=1 instance.
// Expected results are queued when the final beat is driven and compared when
// outmap_vld pulses, including the cycle on which the pulse must appear.

module tb_pe_processing_element;

  logic        clk;
  logic        rst;

  logic [7:0]  weight, inmap, bias;
  logic        inmap_vld, weight_vld;
  logic [7:0]  outmap;
  logic        outmap_vld;
  logic [15:0] vldbiased;

  logic [7:0]  weight1, inmap1, bias1;
  logic        inmap_vld1, weight_vld1;
  logic [7:0]  outmap1;
  logic        outmap_vld1;
  logic [15:0] vldbiased1;

  pe_processing_element #(.PERIOD(25)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .weight     (weight),
    .inmap      (inmap),
    .inmap_vld  (inmap_vld),
    .weight_vld (weight_vld),
    .bias       (bias),
    .outmap     (outmap),
    .outmap_vld (outmap_vld),
    .vldbiased  (vldbiased)
  );

  pe_processing_element #(.PERIOD(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .weight     (weight1),
    .inmap      (inmap1),
    .inmap_vld  (inmap_vld1),
    .weight_vld (weight_vld1),
    .bias       (bias1),
    .outmap     (outmap1),
    .outmap_vld (outmap_vld1),
    .vldbiased  (vldbiased1)
  );

  typedef struct {
    logic [7:0] w;
    logic [7:0] x;
    logic [7:0] b;
    int         vb;
    int         om;
  } vec_t;

  typedef struct {
    int vb;
    int om;
    int cyc;
  } exp_t;

  vec_t tbl[5];
  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard for the PERIOD=25 instance.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].cyc < cyc) begin
      e = q0.pop_front();
      check("p25 missing pulse", 0, 1);
    end
    if (outmap_vld) begin
      if (q0.size() == 0) begin
        check("p25 unexpected pulse", 1, 0);
      end else begin
        e = q0.pop_front();
        check("p25 vldbiased", int'($signed(vldbiased)), e.vb);
        check("p25 outmap", int'($signed(outmap)), e.om);
        check("p25 pulse cycle", cyc, e.cyc);
      end
    end
  end

  // Scoreboard for the PERIOD=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0 && q1[0].cyc < cyc) begin
      e = q1.pop_front();
      check("p1 missing pulse", 0, 1);
    end
    if (outmap_vld1) begin
      if (q1.size() == 0) begin
        check("p1 unexpected pulse", 1, 0);
      end else begin
        e = q1.pop_front();
        check("p1 vldbiased", int'($signed(vldbiased1)), e.vb);
        check("p1 outmap", int'($signed(outmap1)), e.om);
        check("p1 pulse cycle", cyc, e.cyc);
      end
    end
  end

  // One beat on the PERIOD=25 instance; valids drop afterwards unless the
  // next call re-asserts them in the same time step.
  task automatic beat(input logic [7:0] w, input logic [7:0] x, input logic [7:0] b);
    weight     = w;
    inmap      = x;
    bias       = b;
    inmap_vld  = 1'b1;
    weight_vld = 1'b1;
    @(posedge clk);
    #1;
    inmap_vld  = 1'b0;
    weight_vld = 1'b0;
  endtask

  // Non-final beats carry random bias, which must be ignored.
  task automatic run_window(input vec_t v, input int nbeats, input int gap_at,
                            input int gap_len);
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          weight     = 8'($urandom);
          inmap      = 8'($urandom);
          bias       = 8'($urandom);
          inmap_vld  = 1'b0;
          weight_vld = (g % 2 == 0);
          @(posedge clk);
          #1;
        end
      end
      beat(v.w, v.x, (i == 24) ? v.b : 8'($urandom));
      if (i == 24) q0.push_back('{vb: v.vb, om: v.om, cyc: cyc});
    end
  endtask

  task automatic p1_beat(input logic [7:0] w, input logic [7:0] x, input logic [7:0] b,
                         input int vb, input int om);
    weight1     = w;
    inmap1      = x;
    bias1       = b;
    inmap_vld1  = 1'b1;
    weight_vld1 = 1'b1;
    @(posedge clk);
    #1;
    inmap_vld1  = 1'b0;
    weight_vld1 = 1'b0;
    q1.push_back('{vb: vb, om: om, cyc: cyc});
  endtask

  initial begin
    tbl[0] = '{w: 8'd5,   x: 8'd3,   b: 8'd2, vb: 391,    om: 48};
    tbl[1] = '{w: 8'h83,  x: 8'd2,   b: 8'd2, vb: -6234,  om: -128};
    tbl[2] = '{w: 8'd0,   x: 8'd0,   b: 8'd2, vb: 16,     om: 2};
    tbl[3] = '{w: 8'd14,  x: 8'hff,  b: 8'd1, vb: -342,   om: -43};
    tbl[4] = '{w: 8'h80,  x: 8'h80,  b: 8'd2, vb: 32767,  om: 127};

    rst = 1'b0;
    weight = '0; inmap = '0; bias = '0; inmap_vld = 1'b0; weight_vld = 1'b0;
    weight1 = '0; inmap1 = '0; bias1 = '0; inmap_vld1 = 1'b0; weight_vld1 = 1'b0;
    #1;
    check("reset outmap", int'(outmap), 0);
    check("reset vldbiased", int'(vldbiased), 0);
    check("reset outmap_vld", int'(outmap_vld), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic window twice back-to-back, then the remaining table entries.
    run_window(tbl[0], 25, -1, 0);
    for (int t = 0; t < 5; t++) run_window(tbl[t], 25, -1, 0);

    // Valid gap of 7 cycles mid-window.
    run_window(tbl[0], 25, 12, 7);

    // Reset after beat 10: partial window discarded, outputs clear at once.
    run_window(tbl[0], 10, -1, 0);
    #2;
    rst = 1'b0;
    #1;
    check("mid reset outmap", int'(outmap), 0);
    check("mid reset vldbiased", int'(vldbiased), 0);
    check("mid reset outmap_vld", int'(outmap_vld), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_window(tbl[0], 25, -1, 0);

    // PERIOD=1: every beat is final, including after an idle cycle.
    p1_beat(8'd5, 8'd3, 8'd2, 31, 3);
    p1_beat(8'd5, 8'd3, 8'd2, 31, 3);
    weight1 = 8'($urandom);
    weight_vld1 = 1'b1;
    @(posedge clk);
    #1;
    weight_vld1 = 1'b0;
    p1_beat(8'h10, 8'h08, 8'h80, -896, -112);
    p1_beat(8'd5, 8'd3, 8'd2, 31, 3);

    for (int i = 0; i < 40 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    if (q0.size() > 0 || q1.size() > 0) check("drain timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_processing_element.md
# pe_processing_element

Module `pe` is a signed fixed-point multiply-accumulate processing element for the CNN convolution datapath. It accumulates `PERIOD` products of `weight × inmap`, which is one kernel window (25 = 5×5 by default). It then adds a bias and emits both a full-precision result and a saturated 8-bit feature-map value, with a one-cycle valid pulse.

## Interface
- `PERIOD`, default 25: number of valid MAC beats per output window; legal range 1–256.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `weight`  in  8: signed Q4.3 kernel weight.
- `inmap`  in  8: signed Q4.3 input feature-map sample.
- `inmap_vld`  in  1: `inmap` is valid this cycle.
- `weight_vld`  in  1: `weight` is valid this cycle.
- `bias`  in  8: signed Q4.3 bias; sampled on the last beat of a window.
- `outmap`  out  8: signed Q4.3 result, saturated.
- `outmap_vld`  out  1: one-cycle pulse marking new `outmap`/`vldbiased`.
- `vldbiased`  out  16: signed Q9.6 full-precision result, `Σw·x + b`, saturated.

## Operation
- Beat: a rising edge where `inmap_vld && weight_vld`. Non-beat cycles change no accumulator or counter state.
- Product: `p = weight * inmap`, 16-bit signed Q8.6. It is exact, with no overflow possible.
- Accumulator:
  - Internal signed `ACC_W = 17 + clog2(PERIOD)` bits, so it never wraps within a window.
  - Beat counter runs 0..PERIOD-1.
- Beat with count < PERIOD-1: `acc += p` and `count += 1`.
- Beat with count == PERIOD-1 (final beat):
  - `sum = acc + p + (sext(bias) <<< 3)`; the bias is aligned from Q.3 to Q.6.
  - `vldbiased <= sat16(sum)`, clamped to [-32768, 32767].
  - `outmap <= sat8(sum >>> 3)`: arithmetic shift, floor rounding, clamped to [-128, 127].
  - `outmap_vld <= 1`, then `acc <= 0` and `count <= 0`.
- In all other cycles `outmap_vld <= 0`. `outmap` and `vldbiased` hold their last values until the next window completes.
- `bias` is used only on the final beat; changes mid-window have no effect on that window.
- `PERIOD == 1`: every beat is a final beat.
- There is no activation function; ReLU or other activation is applied downstream.

## Timing
- Reset (`rst == 0`, asynchronous): `acc`, `count`, `outmap`, `vldbiased` and `outmap_vld` all clear to 0 immediately. Normal operation resumes on the first rising edge after `rst` rises.
- Reset mid-window discards the partial window; no `outmap_vld` is produced for it.
- Latency: `outmap_vld` is high for exactly the one cycle following the clock edge that registered the final beat. New data is valid on that same edge.
- Throughput: one beat per cycle. Windows are back-to-back with no dead cycle; beat 1 of the next window may coincide with the `outmap_vld` cycle.
- Gaps: if either valid flag drops mid-window, accumulation pauses and resumes on the next beat. The window length counts beats, not cycles.
- There is no backpressure; the consumer must capture results during the `outmap_vld` cycle.

## Test plan
- Basic window. Setup: reset, then PERIOD=25, weight=5, inmap=3, bias=2, both valids held high. Required response:
  - `outmap_vld` pulses after 25 beats.
  - `vldbiased` = 391 (6.109); `outmap` = 48 (6.0).
  - The pulse repeats every 25 cycles.
- Negative saturation: weight=0x83 (-125), inmap=2, bias=2 → `vldbiased` = -6234; `outmap` = -128.
- Zero inputs with bias: weight=0, inmap=0, bias=2 → `vldbiased` = 16; `outmap` = 2.
- Floor rounding and late bias: weight=14, inmap=-1, bias changed to 1 at the window start → `vldbiased` = -342; `outmap` = -43.
- Positive saturation: weight=-128, inmap=-128 (p = 16384) for 25 beats → `vldbiased` = 32767; `outmap` = 127, with no accumulator wrap.
- Control corners, using weight=5, inmap=3, bias=2:
  - Deassert `inmap_vld` for 7 cycles mid-window: the result still equals the 25-beat value, and the pulse is delayed by 7 cycles.
  - Assert reset after beat 10: outputs read 0 immediately, and the next pulse comes 25 beats after reset release.
  - PERIOD=1 instance with weight=5, inmap=3, bias=2: a pulse every beat with `vldbiased` = 31 and `outmap` = 3.
